// File: rtl/dbb_arb_pkg.sv
// Shared definitions for the DRAM read arbiter slice.
//   ID_WIDTH     : width of AR/R transaction IDs
//   arb_state_t  : arbiter FSM state encoding (StIdle, StAddr, StData)
//   grant_t      : requester index (GrantS0 / GrantS1)
package dbb_arb_pkg;

  localparam int unsigned ID_WIDTH = 8;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t StIdle = 2'd0;
  localparam arb_state_t StAddr = 2'd1;
  localparam arb_state_t StData = 2'd2;

  typedef logic grant_t;
  localparam grant_t GrantS0 = 1'b0;
  localparam grant_t GrantS1 = 1'b1;

endpackage

// File: rtl/dbb_rd_arbiter_if.sv
// Read channel bundle (AR + R) shared by requesters and the DRAM side.
//   master : drives arvalid/araddr/arlen/arid/rready, receives arready and R beats
//   slave  : receives AR requests, drives arready and R beats
interface dbb_rd_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 8
);
  import dbb_arb_pkg::*;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0]  arlen;
  logic [ID_WIDTH-1:0]   arid;
  logic                  rvalid;
  logic                  rready;
  logic                  rlast;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_WIDTH-1:0]   rid;

  modport master (
    output arvalid, araddr, arlen, arid, rready,
    input  arready, rvalid, rlast, rdata, rid
  );

  modport slave (
    input  arvalid, araddr, arlen, arid, rready,
    output arready, rvalid, rlast, rdata, rid
  );

endinterface

// File: rtl/dbb_rr_pick.sv
// Two-way winner selection for the read arbiter.
//   req   : request vector, bit N = sN_arvalid
//   last  : previous winner
//   grant : selected requester (only meaningful when req != 0)
// Build option: DBB_RD_ARB_FIXED_PRIO_EN selects fixed priority (s0 wins ties);
// otherwise ties go to the requester that did not win last time.
module dbb_rr_pick
  import dbb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last,
  output grant_t     grant
);

`ifdef DBB_RD_ARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = last;
  assign grant = req[1] & ~req[0];
`else
  always_comb begin
    if (req == 2'b11) begin
      grant = ~last;
    end else begin
      grant = req[1];
    end
  end
`endif

endmodule

// File: rtl/dbb_rd_arbiter.sv
// Two-requester DRAM read arbiter with one burst outstanding downstream.
//   clk, rst_n : clock, asynchronous active-low reset
//   s0, s1     : requester AR/R channels (slave side)
//   m          : DRAM AR/R channel (master side)
//   err_len    : sticky flag, burst ended with beat count != len+1
//   cur_grant  : requester owning the current or last burst
// Build option: DBB_RD_ARB_FIXED_PRIO_EN (evaluated in dbb_rr_pick only).
module dbb_rd_arbiter
  import dbb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  dbb_rd_arbiter_if.slave   s0,
  dbb_rd_arbiter_if.slave   s1,
  dbb_rd_arbiter_if.master  m,
  output logic              err_len,
  output logic              cur_grant
);

  localparam logic [LEN_WIDTH:0] CntOne = {{LEN_WIDTH{1'b0}}, 1'b1};

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  grant_t                r_last;
  grant_t                r_grant;
  grant_t                w_pick;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [ID_WIDTH-1:0]   r_id;
  logic [LEN_WIDTH:0]    r_cnt;
  logic                  r_err;

  logic [1:0]            w_req;
  logic                  w_accept;
  logic                  w_sel0;
  logic                  w_sel1;
  logic                  w_rhs;
  logic                  w_ar_done;
  logic [LEN_WIDTH:0]    w_cnt_inc;
  logic [LEN_WIDTH:0]    w_beats_exp;

  assign w_req = {s1.arvalid, s0.arvalid};

  dbb_rr_pick u_pick (
    .req   (w_req),
    .last  (r_last),
    .grant (w_pick)
  );

  assign w_accept = (r_state == StIdle) && (w_req != 2'b00);

  // rst_n gates arready so nothing is acknowledged while reset is held.
  assign s0.arready = rst_n & w_accept & (w_pick == GrantS0);
  assign s1.arready = rst_n & w_accept & (w_pick == GrantS1);

  assign m.arvalid = (r_state == StAddr);
  assign m.araddr  = r_addr;
  assign m.arlen   = r_len;
  assign m.arid    = r_id;

  assign w_ar_done = (r_state == StAddr) && m.arready;

  // R path is a pure combinational route to the granted requester while in DATA.
  assign w_sel0 = (r_state == StData) && (r_grant == GrantS0);
  assign w_sel1 = (r_state == StData) && (r_grant == GrantS1);

  assign m.rready  = (w_sel0 & s0.rready) | (w_sel1 & s1.rready);
  assign w_rhs     = m.rvalid & m.rready;

  assign s0.rvalid = w_sel0 & m.rvalid;
  assign s0.rlast  = w_sel0 & m.rlast;
  assign s0.rdata  = w_sel0 ? m.rdata : {DATA_WIDTH{1'b0}};
  assign s0.rid    = w_sel0 ? m.rid   : {ID_WIDTH{1'b0}};

  assign s1.rvalid = w_sel1 & m.rvalid;
  assign s1.rlast  = w_sel1 & m.rlast;
  assign s1.rdata  = w_sel1 ? m.rdata : {DATA_WIDTH{1'b0}};
  assign s1.rid    = w_sel1 ? m.rid   : {ID_WIDTH{1'b0}};

  // Count includes the beat being transferred, compared against len+1.
  assign w_cnt_inc   = r_cnt + CntOne;
  assign w_beats_exp = {1'b0, r_len} + CntOne;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: if (w_accept)          w_state_nxt = StAddr;
      StAddr: if (m.arready)         w_state_nxt = StData;
      StData: if (w_rhs && m.rlast)  w_state_nxt = StIdle;
      default:                       w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_last  <= GrantS1;
      r_grant <= GrantS0;
      r_addr  <= '0;
      r_len   <= '0;
      r_id    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_grant <= w_pick;
        r_last  <= w_pick;
        r_addr  <= (w_pick == GrantS1) ? s1.araddr : s0.araddr;
        r_len   <= (w_pick == GrantS1) ? s1.arlen  : s0.arlen;
        r_id    <= (w_pick == GrantS1) ? s1.arid   : s0.arid;
      end
      if (w_ar_done) begin
        r_cnt <= '0;
      end else if (w_rhs) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_rhs && m.rlast && (w_cnt_inc != w_beats_exp)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_len   = r_err;
  assign cur_grant = r_grant;

endmodule

// File: doc/dbb_rd_arbiter.md
DBB_RD_ARBITER -- requirements
Module: dbb_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the AR address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, the R data width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, the burst-length field width (beats = len+1).
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports sN_arvalid (input, 1), sN_arready (output, 1), sN_araddr (input, ADDR_WIDTH), sN_arlen (input, LEN_WIDTH) and sN_arid (input, 8) for N = 0 and 1: requester read-address channels.
REQ-007 SHALL have ports sN_rvalid (output, 1), sN_rready (input, 1), sN_rlast (output, 1), sN_rdata (output, DATA_WIDTH) and sN_rid (output, 8) for N = 0 and 1: requester read-data channels.
REQ-008 SHALL have ports m_arvalid (output, 1), m_arready (input, 1), m_araddr (output, ADDR_WIDTH), m_arlen (output, LEN_WIDTH) and m_arid (output, 8): downstream DRAM read-address channel.
REQ-009 SHALL have ports m_rvalid (input, 1), m_rready (output, 1), m_rlast (input, 1), m_rdata (input, DATA_WIDTH) and m_rid (input, 8): downstream DRAM read-data channel.
REQ-010 SHALL have port err_len, output, 1 bit: sticky burst-length mismatch flag.
REQ-011 SHALL have port cur_grant, output, 1 bit: index of the requester owning the current or last burst.

Function
REQ-012 SHALL implement FSM states IDLE, ADDR and DATA, with exactly one burst outstanding downstream at any time.
REQ-013 In IDLE with any sN_arvalid high, SHALL select a winner, assert sN_arready only for the winner (combinational, same cycle), latch its addr/len/id, set cur_grant, and move to ADDR.
REQ-014 In IDLE with no sN_arvalid high, SHALL hold every arready low and stay in IDLE.
REQ-015 When both requesters request, SHALL grant the requester that did not win the previous grant; the first grant after reset SHALL go to s0.
REQ-016 In ADDR, SHALL drive m_arvalid=1 with the latched fields, unchanged until m_arready; on m_arready, SHALL move to DATA; the latency from request acceptance to m_arvalid SHALL be 1 cycle.
REQ-017 In DATA, SHALL connect the granted requester combinationally: s{g}_rvalid=m_rvalid, s{g}_rlast/rdata/rid=m_*, m_rready=s{g}_rready; the other requester's rvalid SHALL be 0.
REQ-018 Outside DATA, SHALL drive m_rready=0 and both s_rvalid=0.
REQ-019 SHALL count R handshakes in a LEN_WIDTH+1-bit counter cleared on entry to DATA.
REQ-020 On an R handshake with m_rlast=1, SHALL return to IDLE at the next edge; the counter value (including this beat) SHALL be compared against len+1.
REQ-021 On mismatch, SHALL set err_len=1 until reset and still return to IDLE.
REQ-022 A new request SHALL be accepted no earlier than the cycle after the return to IDLE (no IDLE bypass).
REQ-023 Arvalid dropping while not granted SHALL be tolerated; the requester simply loses arbitration that cycle.

Reset
REQ-024 On reset (including mid-burst), SHALL force the FSM to IDLE, the previous-winner record to s1 (so s0 wins next), the counter to 0, err_len to 0, cur_grant to 0, all arready/rvalid/m_arvalid/m_rready to 0, and latched fields to 0.
REQ-025 Release SHALL be synchronous with clk internally; the first grant SHALL be possible on the first edge after release.

Configuration
REQ-026 With macro DBB_RD_ARB_FIXED_PRIO_EN defined, SHALL use fixed priority: s0 always wins when both request.
REQ-027 Without DBB_RD_ARB_FIXED_PRIO_EN, SHALL use the round-robin rule of REQ-015.

Structure
REQ-028 SHALL take the FSM state enum, the grant type and the ID width constant (8) from shared package dbb_arb_pkg.
REQ-029 SHALL put winner selection in sub-module dbb_rr_pick (inputs req[1:0] and last; output grant), which is the only place the macro is evaluated.

Verification
REQ-030 The bench SHALL cover: s0 alone requests addr 0x40, len 3 -> m_araddr=0x40 one cycle after acceptance; 4 beats routed to s0 with rlast on the 4th; s1_rvalid stays 0.
REQ-031 The bench SHALL cover: s0 and s1 request continuously (round-robin build) -> grants alternate s0, s1, s0, s1.
REQ-032 The bench SHALL cover: the same stimulus with DBB_RD_ARB_FIXED_PRIO_EN -> all grants go to s0 while it requests.
REQ-033 The bench SHALL cover: len=3 but DRAM asserts rlast on beat 2 -> err_len=1 from the next cycle and the FSM returns to IDLE.
REQ-034 The bench SHALL cover: rst_n asserted during beat 2 of a len=7 burst -> all outputs at reset values; the next s1 request after release is served correctly.
REQ-035 The bench SHALL cover: s1_rready held low for 5 cycles mid-burst -> m_rready=0 throughout, no beat lost, and the beat count equals 8 for len=7.
